count_sequencer: RTL
====================

// Module: count_sequencer
// PURPOSE
// Round-robin sequencer that shares one 8-bit event counter between N_REQ requesters.
// - Each request is a run length; the block clears the counter and enables it for that many counts.
// - It then reports the result with a one-cycle done pulse.
// - Sits between requesting control FSMs and the counter datapath.
// PARAMETERS
// WIDTH  8  counter / run-length width
// N_REQ  2  number of requesters (>=2)
// PORTS
// Clock         in   1              rising-edge clock
// Reset         in   1              asynchronous, active-high
// req_valid     in   N_REQ          request pending, one bit per requester
// req_len       in   N_REQ*WIDTH    run length; requester i uses bits [i*WIDTH +: WIDTH]
// req_ready     out  N_REQ          one-hot grant; accept = req_valid[i] & req_ready[i]
// pause         in   1              hold counter (Enable low) while RUN
// abort         in   1              terminate current run early
// busy          out  1              state != IDLE
// count         out  WIDTH          live counter value Q
// done          out  1              one-cycle completion pulse
// done_id       out  $clog2(N_REQ)  requester of completed run
// done_count    out  WIDTH          Q at completion
// done_aborted  out  1              run ended by abort
// BEHAVIOUR
// Reset values (async):
// - state=IDLE; Q=0; rr_ptr=0 (requester 0 has first priority).
// - Latched len/id = 0; all outputs 0.
// States IDLE -> RUN | DONE -> DONE -> IDLE.
// IDLE:
// - req_ready = one-hot of the first valid requester, searching from rr_ptr upward with wrap.
// - req_ready = 0 if no request is valid.
// - On accept: latch len_r, id_r, and pulse Clear to the counter (Q=0 next cycle).
// - If len==0, go directly to DONE (done_count=0). Otherwise go to RUN.
// RUN:
// - Enable = !pause & !abort. Q increments by 1 per enabled cycle.
// - If Enable and Q==len_r-1, go to DONE; Q==len_r in DONE.
// - abort: go to DONE with aborted=1. Enable is suppressed, so Q is frozen.
// - abort has priority over terminal increment in the same cycle.
// DONE:
// - done=1, done_id=id_r, done_count=Q, done_aborted as latched.
// - rr_ptr <= (id_r+1) mod N_REQ. Next state IDLE.
// Timing and outputs:
// - req_ready is 0 in RUN and DONE. A new accept is earliest the cycle after DONE.
// - Latency: accept at cycle t, Q=0 at t+1, done at t+1+len (no pause). Each pause cycle adds 1.
// - done_* outputs hold their last value outside DONE. Only done is a pulse.
// - Q never wraps: len_r <= 2^WIDTH-1 and counting stops at len_r.
// - pause and abort are ignored in IDLE and DONE.
// - Reset mid-run: immediate return to reset values. No done pulse is issued.
// - req_len is sampled only in the accept cycle. Later changes have no effect.
// CONFIGURATION
// Macro COUNT_SEQ_ASSERT_EN:
// - Defined: concurrent SVA compiled in.
//   - Reset |-> Q==0.
//   - $onehot0(req_ready).
//   - RUN & Enable |=> Q==$past(Q)+1.
//   - RUN & !Enable |=> Q==$past(Q).
//   - done |-> Q==len_r || done_aborted.
//   - done |=> !done.
// - Undefined: no assertions. RTL function is identical.
// STRUCTURE
// Package count_seq_pkg:
// - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e.
// - localparam int CNT_W = 8.
// Sub-module seq_counter:
// - Ports: Clock, Reset (async), Clear (sync, priority over Enable), Enable, Q[WIDTH].
// - Instanced once.
// Top level holds the FSM, round-robin pointer and output registers.
// TESTING
// 1. Req0 len=5 alone: ready0 at t, Q 0..5, done at t+6, id=0, count=5, aborted=0.
// 2. Req0 and req1 both valid, len=3 each: req0 served first, then req1. Next contest grants req0 again (alternation).
// 3. len=0: done one cycle after accept with count=0. No counter increment.
// 4. len=10, pause for 4 cycles mid-run: done 4 cycles later, count=10.
// 5. len=20, abort when Q=7: done next cycle, count=7, aborted=1. Abort together with Q==len-1: count=len-1, aborted=1.
// 6. Reset asserted at Q=3: Q=0, busy=0, no done. Fresh request after release runs normally with req0 priority.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer slice.
//   seq_state_e : sequencer FSM encoding (IDLE, RUN, DONE)
//   CNT_W       : default counter / run-length width
package count_seq_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_counter.sv
// Event counter shared by all requesters.
// Ports:
//   Clock  in  rising-edge clock
//   Reset  in  asynchronous, active-high
//   Clear  in  synchronous clear, wins over Enable
//   Enable in  count up by one
//   Q      out live counter value
module seq_counter
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Enable,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_q <= '0;
    end else if (Clear) begin
      r_q <= '0;
    end else if (Enable) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/count_sequencer.sv
// Round-robin sequencer sharing one event counter between N_REQ requesters.
// Each accepted request clears the counter, counts up to its run length
// (or until aborted) and reports the outcome with a one-cycle done pulse.
// Optional macro COUNT_SEQ_ASSERT_EN compiles in concurrent checks.
// Ports:
//   Clock, Reset              clock, asynchronous active-high reset
//   req_valid / req_len       per-requester request and run length
//   req_ready                 one-hot grant (combinational, IDLE only)
//   pause / abort             hold / terminate the current run
//   busy                      sequencer not idle
//   count                     live counter value
//   done, done_id,
//   done_count, done_aborted  completion report (done_* hold between runs)
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W,
  parameter int unsigned N_REQ = 2
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_len,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     pause,
  input  logic                     abort,
  output logic                     busy,
  output logic [WIDTH-1:0]         count,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [WIDTH-1:0]         done_count,
  output logic                     done_aborted
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic [WIDTH-1:0] r_len;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_rr_ptr;
  logic             r_busy;
  logic             r_done;
  logic [ID_W-1:0]  r_done_id;
  logic [WIDTH-1:0] r_done_count;
  logic             r_done_aborted;

  logic [WIDTH-1:0] w_q;
  logic             w_clear;
  logic             w_enable;
  logic             w_accept;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_idx;
  logic             w_found;
  logic [ID_W-1:0]  w_sel_id;
  logic [WIDTH-1:0] w_sel_len;
  logic [WIDTH-1:0] w_done_cnt;
  logic             w_done_ab;
  logic [WIDTH-1:0] w_len_arr [N_REQ];

  // Unpack the flat length bus so it can be indexed by requester id
  for (genvar i = 0; i < N_REQ; i++) begin : g_len
    assign w_len_arr[i] = req_len[i*WIDTH +: WIDTH];
  end

  seq_counter #(.WIDTH(WIDTH)) u_counter (
    .Clock  (Clock),
    .Reset  (Reset),
    .Clear  (w_clear),
    .Enable (w_enable),
    .Q      (w_q)
  );

  // Round-robin search from r_rr_ptr upward with wrap; grants only in IDLE
  always_comb begin
    w_grant   = '0;
    w_sel_id  = '0;
    w_sel_len = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    if (r_state == IDLE) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        w_idx = ID_W'((32'(r_rr_ptr) + k) % N_REQ);
        if (!w_found && req_valid[w_idx]) begin
          w_found        = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_sel_id       = w_idx;
          w_sel_len      = w_len_arr[w_idx];
        end
      end
    end
  end

  assign w_accept = |w_grant;

  // FSM state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state, counter control and the completion values to capture
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_enable   = 1'b0;
    w_done_cnt = w_q;
    w_done_ab  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_clear    = 1'b1;
          w_done_cnt = '0;
          w_next     = (w_sel_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_enable = !pause && !abort;
        // Abort freezes Q and wins over a terminal increment
        if (abort) begin
          w_next    = DONE;
          w_done_ab = 1'b1;
        end else if (w_enable && (w_q == r_len - WIDTH'(1))) begin
          w_next     = DONE;
          w_done_cnt = w_q + WIDTH'(1);
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request latches, round-robin pointer and registered outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_len          <= '0;
      r_id           <= '0;
      r_rr_ptr       <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_done_id      <= '0;
      r_done_count   <= '0;
      r_done_aborted <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      if (w_accept) begin
        r_len <= w_sel_len;
        r_id  <= w_sel_id;
      end
      if (w_next == DONE) begin
        r_done_id      <= (r_state == IDLE) ? w_sel_id : r_id;
        r_done_count   <= w_done_cnt;
        r_done_aborted <= w_done_ab;
      end
      if (r_state == DONE) begin
        r_rr_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + ID_W'(1);
      end
    end
  end

  assign req_ready    = w_grant;
  assign busy         = r_busy;
  assign count        = w_q;
  assign done         = r_done;
  assign done_id      = r_done_id;
  assign done_count   = r_done_count;
  assign done_aborted = r_done_aborted;

`ifdef COUNT_SEQ_ASSERT_EN
  a_reset_q: assert property (@(posedge Clock) Reset |-> (w_q == '0));
  a_onehot_ready: assert property (@(posedge Clock) disable iff (Reset)
    $onehot0(req_ready));
  a_run_inc: assert property (@(posedge Clock) disable iff (Reset)
    (r_state == RUN && w_enable) |=> (w_q == $past(w_q) + WIDTH'(1)));
  a_run_hold: assert property (@(posedge Clock) disable iff (Reset)
    (r_state == RUN && !w_enable) |=> (w_q == $past(w_q)));
  a_done_q: assert property (@(posedge Clock) disable iff (Reset)
    done |-> ((w_q == r_len) || done_aborted));
  a_done_pulse: assert property (@(posedge Clock) disable iff (Reset)
    done |=> !done);
`else
  // Checks compiled out; function is unchanged.
`endif

endmodule
